weight_enum: RTL
================

# weight_enum

Sequential enumerator that does the reverse of the team's ones-counting logic. A popcount block maps a word to its number of set bits. This block takes a count `k` and streams, in ascending numeric order, every N-bit word whose popcount is exactly `k`. That is C(N,k) words, with a valid/ready handshake on the output. It serves as a stimulus source for popcount, comparator and adder datapaths, and as a combination generator for selection logic.

## Interface
- `N`, 8, word width in bits; N ≥ 2.
- `W`, derived (localparam, not overridable), `$clog2(N+1)`: width that holds the values 0..N.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new enumeration; sampled only in IDLE.
- `k`  in  W  target popcount; sampled together with `start`.
- `busy`  out  1  high from the cycle after an accepted start until the done cycle.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer accepts `out_word`.
- `out_word`  out  N  current enumerated word.
- `out_last`  out  1  qualifies `out_word` as the final word of the enumeration.
- `done`  out  1  one-cycle pulse after the final handshake.
- `err`  out  1  one-cycle pulse when `start` arrives with k > N.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - `start`=1 and k > N: pulse `err` next cycle, stay IDLE, emit nothing.
  - `start`=1 and k = 0: load `out_word`=0 and `out_last`=1, then go to EMIT.
  - `start`=1 and 1 ≤ k ≤ N: load `out_word`=(1<<k)−1, then go to EMIT.
    - `out_last`=1 when the loaded word equals `lastw`.
    - `lastw` = ((1<<k)−1)<<(N−k), the k ones packed at the MSB end.
    - For k = N the first word is already `lastw`, so exactly one word is emitted.
- EMIT:
  - `out_valid`=1 and `busy`=1.
  - Handshake: a transfer occurs on a cycle with `out_valid` & `out_ready`.
  - Transfer of a non-last word: `out_word` ← next(x), where x is the current word.
    - next(x) = r | ((x ^ r) >> (tz+2)).
    - c = x & (−x), the lowest set bit.
    - r = x + c.
    - tz = trailing-zero count of x.
    - Shift-based; no divider.
    - All intermediate values fit in N bits for any non-last word.
    - `out_last` is recomputed as (next(x) == `lastw`).
  - Transfer of the last word: go to IDLE, pulse `done`, clear `out_valid`, `out_last` and `busy`.
  - No transfer: `out_word` and `out_last` hold stable.
- `start` is ignored while `busy` or while in EMIT.
- `k` is latched at accept. Later changes to `k` have no effect on the current enumeration.
- Words are strictly increasing. Every emitted word has popcount k, and no word repeats.

## Timing
- Reset values, applied on the first clock edge with `rst`=1:
  - `busy`, `out_valid`, `out_last`, `done`, `err` = 0.
  - `out_word` = 0.
  - State = IDLE.
- `rst` mid-enumeration aborts immediately. No `done` pulse is generated, and the enumeration is lost.
- `start` accepted at edge t: `out_valid`=1 and `busy`=1 from cycle t+1.
- `err` for a rejected start is high in cycle t+1 only. `busy` stays 0.
- Throughput is one word per cycle while `out_ready` is held high, with no bubbles.
- Total enumeration length with `out_ready` held high: C(N,k) handshake cycles + 1 done cycle.
- `done` is high in the cycle after the final handshake, with `out_valid`=0.
- A new `start` is accepted in that `done` cycle at the earliest.
- `out_valid` never drops without a transfer; the output is AXI-style stable.

## Test plan
- N=4, k=2, `out_ready`=1:
  - Required: `out_word` sequence 0011, 0101, 0110, 1001, 1010, 1100 on 6 consecutive cycles.
  - Required: `out_last` set only with 1100.
  - Required: `done` high one cycle later, then `busy` low.
- N=4 corner counts:
  - k=0 → single word 0000 with `out_last`=1.
  - k=4 → single word 1111 with `out_last`=1.
  - k=1 → 0001, 0010, 0100, 1000.
- N=4, k=5 → `err` high one cycle; `out_valid` and `busy` stay 0; no words emitted.
- N=8, k=3, random `out_ready`:
  - Required: exactly 56 transfers, strictly ascending.
  - Required: every word has popcount 3, checked with the Counting1s popcount block.
  - Required: `out_word` stable whenever `out_valid` & !`out_ready`.
- Assert `rst` for one cycle after the 3rd word of N=8, k=2:
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Then `start` with k=1: required first word is 00000001.
- Pulse `start` with k=6 during an N=8, k=2 enumeration:
  - Required: the stream is unaffected and completes its 28 words.
  - Required: `start` in the `done` cycle is accepted.

Source files
------------

// File: rtl/weight_enum.sv
`default_nettype none
// ============================================================================
// Module      : weight_enum
// Description : Streams every N-bit word with popcount k in ascending order
//               over a valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================

module weight_enum #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(N+1)-1:0]   k,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_word,
    output logic                     out_last,
    output logic                     done,
    output logic                     err
);

    localparam int W = $clog2(N + 1);

    localparam logic [0:0]   c_IDLE = 1'b0;
    localparam logic [0:0]   c_EMIT = 1'b1;
    localparam logic [W-1:0] c_N    = W'(N);
    localparam logic [N-1:0] c_ONE  = N'(1);
    localparam logic [W:0]   c_TWO  = (W+1)'(2);

    logic [0:0]   r_state;
    logic [N-1:0] r_word;
    logic [N-1:0] r_lastw;
    logic         r_last;
    logic         r_done;
    logic         r_err;

    logic         w_idle;
    logic         w_start_ok;
    logic         w_start_bad;
    logic [N-1:0] w_ones;
    logic [N-1:0] w_lastw;
    logic [N-1:0] w_low;
    logic [N-1:0] w_ripple;
    logic [W-1:0] w_tz;
    logic [W:0]   w_sh;
    logic [N-1:0] w_next;

    assign w_idle      = (r_state == c_IDLE);
    assign w_start_ok  = w_idle && start && (k <= c_N);
    assign w_start_bad = w_idle && start && (k > c_N);

    // For k == N the shift wraps to zero, so the subtraction yields all ones.
    assign w_ones  = (c_ONE << k) - c_ONE;
    assign w_lastw = w_ones << (c_N - k);

    // Gosper successor: carry the lowest run upward, refill remaining ones at the bottom.
    assign w_low    = r_word & ((~r_word) + c_ONE);
    assign w_ripple = r_word + w_low;

    always_comb begin
        w_tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_word[i]) begin
                w_tz = W'(i);
            end
        end
    end

    assign w_sh   = {1'b0, w_tz} + c_TWO;
    assign w_next = w_ripple | ((r_word ^ w_ripple) >> w_sh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_word  <= '0;
            r_lastw <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_start_bad;
            if (r_state == c_IDLE) begin
                if (w_start_ok) begin
                    r_state <= c_EMIT;
                    r_word  <= w_ones;
                    r_lastw <= w_lastw;
                    r_last  <= (w_ones == w_lastw);
                end
            end else begin
                if (out_ready) begin
                    if (r_last) begin
                        r_state <= c_IDLE;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_word <= w_next;
                        r_last <= (w_next == r_lastw);
                    end
                end
            end
        end
    end

    assign busy      = (r_state == c_EMIT);
    assign out_valid = (r_state == c_EMIT);
    assign out_word  = r_word;
    assign out_last  = r_last;
    assign done      = r_done;
    assign err       = r_err;

    // Output stability and ordering guarantees seen by the consumer.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_word) && $stable(out_last)));

    a_ascend: assert property (@(posedge clk) disable iff (rst)
        (out_valid && out_ready && !out_last) |=> (out_valid && (out_word > $past(out_word))));

    a_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(done && out_valid));

endmodule

`default_nettype wire
